// File: rtl/tlb_cfg_axil_queue.sv
// AXI4-Lite staging registers for TLB/config entries, committed into a FIFO that is drained
// over an AXI4-Stream master (one beat per entry).
module tlb_cfg_axil_queue #(
  parameter int unsigned N_WORDS        = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          AUTO_DEFAULT   = 1'b1,
  parameter int unsigned AXIL_DATA_BITS = 64,
  parameter int unsigned AXIL_ADDR_BITS = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [AXIL_ADDR_BITS-1:0]          s_axi_ctrl_awaddr_i,
  input  logic                               s_axi_ctrl_awvalid_i,
  output logic                               s_axi_ctrl_awready_o,
  input  logic [AXIL_DATA_BITS-1:0]          s_axi_ctrl_wdata_i,
  input  logic [AXIL_DATA_BITS/8-1:0]        s_axi_ctrl_wstrb_i,
  input  logic                               s_axi_ctrl_wvalid_i,
  output logic                               s_axi_ctrl_wready_o,
  output logic [1:0]                         s_axi_ctrl_bresp_o,
  output logic                               s_axi_ctrl_bvalid_o,
  input  logic                               s_axi_ctrl_bready_i,
  input  logic [AXIL_ADDR_BITS-1:0]          s_axi_ctrl_araddr_i,
  input  logic                               s_axi_ctrl_arvalid_i,
  output logic                               s_axi_ctrl_arready_o,
  output logic [AXIL_DATA_BITS-1:0]          s_axi_ctrl_rdata_o,
  output logic [1:0]                         s_axi_ctrl_rresp_o,
  output logic                               s_axi_ctrl_rvalid_o,
  input  logic                               s_axi_ctrl_rready_i,
  output logic [N_WORDS*AXIL_DATA_BITS-1:0]  m_axis_tdata_o,
  output logic                               m_axis_tvalid_o,
  input  logic                               m_axis_tready_i,
  output logic                               m_axis_tlast_o
);

  localparam int unsigned EB      = N_WORDS * AXIL_DATA_BITS;
  localparam int unsigned NBytes  = AXIL_DATA_BITS / 8;
  localparam int unsigned AddrLsb = $clog2(NBytes);
  localparam int unsigned IdxW    = AXIL_ADDR_BITS - AddrLsb;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0]  RespOk  = 2'b00;
  localparam logic [1:0]  RespErr = 2'b10;

  logic [N_WORDS-1:0][AXIL_DATA_BITS-1:0] words_q, words_d;
  logic                      auto_q, auto_d;
  logic                      awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AXIL_DATA_BITS-1:0] rdata_q, rdata_d;
  logic [EB-1:0]             mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q, fill;
  logic [15:0]               drop_cnt_q, drop_cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      wr_hs, ar_hs, commit, clr_ovf, empty, full, pop, push, drop;
  logic [IdxW-1:0]           aw_idx, ar_idx;
  logic                      unused_addr;

  assign aw_idx      = s_axi_ctrl_awaddr_i[AXIL_ADDR_BITS-1:AddrLsb];
  assign ar_idx      = s_axi_ctrl_araddr_i[AXIL_ADDR_BITS-1:AddrLsb];
  assign unused_addr = ^{s_axi_ctrl_awaddr_i[AddrLsb-1:0], s_axi_ctrl_araddr_i[AddrLsb-1:0]};

  assign wr_hs = awready_q & s_axi_ctrl_awvalid_i & s_axi_ctrl_wvalid_i;
  assign ar_hs = arready_q & s_axi_ctrl_arvalid_i;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign empty = (fill == '0);
  assign full  = (fill == PtrW'(FIFO_DEPTH));
  assign pop   = ~empty & m_axis_tready_i;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push  = commit & (~full | pop);
  assign drop  = commit & ~push;

  // Register writes; the commit snapshot is taken from words_d so same-cycle bytes are included.
  always_comb begin
    words_d = words_q;
    auto_d  = auto_q;
    commit  = 1'b0;
    clr_ovf = 1'b0;
    bresp_d = RespOk;
    if (wr_hs) begin
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        if (aw_idx == IdxW'(i)) begin
          for (int unsigned b = 0; b < NBytes; b++) begin
            if (s_axi_ctrl_wstrb_i[b]) words_d[i][b*8 +: 8] = s_axi_ctrl_wdata_i[b*8 +: 8];
          end
        end
      end
      if (auto_q && aw_idx == IdxW'(N_WORDS - 1) && |s_axi_ctrl_wstrb_i) commit = 1'b1;
      if (aw_idx == IdxW'(N_WORDS)) begin
        if (s_axi_ctrl_wstrb_i[0]) begin
          auto_d  = s_axi_ctrl_wdata_i[2];
          commit  = s_axi_ctrl_wdata_i[0];
          clr_ovf = s_axi_ctrl_wdata_i[1];
        end
      end else if (aw_idx > IdxW'(N_WORDS + 1)) begin
        bresp_d = RespErr;
      end
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (drop) begin
      drop_cnt_d = clr_ovf ? 16'd1 : ((drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1);
      ovf_d      = 1'b1;
    end else if (clr_ovf) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = RespOk;
    for (int unsigned i = 0; i < N_WORDS; i++) begin
      if (ar_idx == IdxW'(i)) rdata_d = words_q[i];
    end
    if (ar_idx == IdxW'(N_WORDS)) begin
      rdata_d[2] = auto_q;
    end else if (ar_idx == IdxW'(N_WORDS + 1)) begin
      rdata_d[15:0]    = drop_cnt_q;
      rdata_d[16]      = ovf_q;
      rdata_d[17]      = empty;
      rdata_d[18]      = full;
      rdata_d[32 +: 8] = 8'(fill);
    end else if (ar_idx > IdxW'(N_WORDS + 1)) begin
      rresp_d = RespErr;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      words_q    <= '0;
      auto_q     <= AUTO_DEFAULT;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOk;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RespOk;
      rdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      words_q    <= words_d;
      auto_q     <= auto_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      awready_q  <= s_axi_ctrl_awvalid_i & s_axi_ctrl_wvalid_i & ~bvalid_q & ~awready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (s_axi_ctrl_bready_i) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= s_axi_ctrl_arvalid_i & ~rvalid_q & ~arready_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (s_axi_ctrl_rready_i) begin
        rvalid_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[PtrW-2:0]] <= words_d;
  end

  assign s_axi_ctrl_awready_o = awready_q;
  assign s_axi_ctrl_wready_o  = awready_q;
  assign s_axi_ctrl_bvalid_o  = bvalid_q;
  assign s_axi_ctrl_bresp_o   = bresp_q;
  assign s_axi_ctrl_arready_o = arready_q;
  assign s_axi_ctrl_rvalid_o  = rvalid_q;
  assign s_axi_ctrl_rdata_o   = rdata_q;
  assign s_axi_ctrl_rresp_o   = rresp_q;
  assign m_axis_tdata_o       = mem_q[rd_ptr_q[PtrW-2:0]];
  assign m_axis_tvalid_o      = ~empty;
  assign m_axis_tlast_o       = 1'b1;

endmodule

// File: tb/tb_tlb_cfg_axil_queue.sv
// Bench for tlb_cfg_axil_queue: directed sequences, a vector table and a randomized phase,
// all checked against a queue-based model of the register map and entry FIFO.
module tb_tlb_cfg_axil_queue;
  localparam int NW = 2;
  localparam int D  = 4;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [15:0]  awaddr = '0, araddr = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [63:0]  wdata = '0;
  logic [7:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid, tvalid, tlast;
  logic         tready = 1'b0;
  logic [1:0]   bresp, rresp;
  logic [63:0]  rdata;
  logic [127:0] tdata;

  always #5 aclk = ~aclk;

  tlb_cfg_axil_queue dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axi_ctrl_awaddr_i  (awaddr),
    .s_axi_ctrl_awvalid_i (awvalid),
    .s_axi_ctrl_awready_o (awready),
    .s_axi_ctrl_wdata_i   (wdata),
    .s_axi_ctrl_wstrb_i   (wstrb),
    .s_axi_ctrl_wvalid_i  (wvalid),
    .s_axi_ctrl_wready_o  (wready),
    .s_axi_ctrl_bresp_o   (bresp),
    .s_axi_ctrl_bvalid_o  (bvalid),
    .s_axi_ctrl_bready_i  (bready),
    .s_axi_ctrl_araddr_i  (araddr),
    .s_axi_ctrl_arvalid_i (arvalid),
    .s_axi_ctrl_arready_o (arready),
    .s_axi_ctrl_rdata_o   (rdata),
    .s_axi_ctrl_rresp_o   (rresp),
    .s_axi_ctrl_rvalid_o  (rvalid),
    .s_axi_ctrl_rready_i  (rready),
    .m_axis_tdata_o       (tdata),
    .m_axis_tvalid_o      (tvalid),
    .m_axis_tready_i      (tready),
    .m_axis_tlast_o       (tlast)
  );

  int n_cmp = 0;
  int n_err = 0;
  int beats = 0;

  // Reference model: staged words, AUTO flag, committed entries, drop accounting.
  logic [63:0]  m_words [NW];
  bit           m_auto;
  logic [127:0] m_q [$];
  int           m_drop;
  bit           m_ovf;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_words[0] = '0;
    m_words[1] = '0;
    m_auto = 1'b1;
    m_q.delete();
    m_drop = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_write(input int idx, input logic [63:0] data, input logic [7:0] strb);
    bit commit = 0, clr = 0, dropped = 0;
    if (idx < NW) begin
      for (int b = 0; b < 8; b++) if (strb[b]) m_words[idx][8*b +: 8] = data[8*b +: 8];
      if (m_auto && idx == NW - 1 && strb != 0) commit = 1;
    end else if (idx == NW && strb[0]) begin
      m_auto = data[2];
      commit = data[0];
      clr    = data[1];
    end
    if (commit) begin
      if (m_q.size() < D) m_q.push_back({m_words[1], m_words[0]});
      else dropped = 1;
    end
    if (dropped) begin
      m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
      m_ovf  = 1'b1;
    end else if (clr) begin
      m_drop = 0;
      m_ovf  = 1'b0;
    end
  endtask

  task automatic model_read(input int idx, output logic [63:0] data, output logic [1:0] resp);
    int sz = m_q.size();
    data = '0;
    resp = 2'b00;
    if (idx < NW) data = m_words[idx];
    else if (idx == NW) data = m_auto ? 64'h4 : 64'h0;
    else if (idx == NW + 1)
      data = 64'(m_drop) + (64'(m_ovf) << 16) + (64'(sz == 0) << 17) + (64'(sz == D) << 18)
           + (64'(sz) << 32);
    else resp = 2'b10;
  endtask

  // Beat monitor: each accepted beat must be the oldest committed entry.
  always @(negedge aclk) begin
    if (aresetn && tvalid && tready) begin
      beats++;
      if (m_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_unexpected: got %h, expected no beat", tdata);
      end else begin
        check("beat_data", tdata, m_q.pop_front());
        check("beat_tlast", 128'(tlast), 128'(1));
      end
    end
  end

  // Called and returning at posedge+1. hs_tready >= 0 forces tready during the handshake cycle.
  task automatic axil_write(input int idx, input logic [63:0] data, input logic [7:0] strb,
                            input int hs_tready, output logic [1:0] resp, output logic tv_after);
    bit ok = 0;
    logic saved;
    resp = 2'bxx;
    tv_after = 1'bx;
    awaddr = 16'(idx * 8);
    wdata = data;
    wstrb = strb;
    awvalid = 1'b1;
    wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge aclk); #1;
      if (awready && wready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout: got no awready, expected awready within 50 cycles");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    saved = tready;
    if (hs_tready >= 0) tready = hs_tready[0];
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    tready = saved;
    model_write(idx, data, strb);
    @(negedge aclk);
    tv_after = tvalid;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (bvalid) begin ok = 1; break; end
      @(negedge aclk);
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL b_timeout: got no bvalid, expected bvalid within 50 cycles");
    end else begin
      resp = bresp;
      check("bresp", 128'(resp), (idx > NW + 1) ? 128'd2 : 128'd0);
    end
    @(posedge aclk); #1;
  endtask

  // tready is held low for the read so the captured STATUS matches the model.
  task automatic axil_read(input int idx, output logic [63:0] data, output logic [1:0] resp);
    bit ok = 0;
    logic saved = tready;
    data = 'x;
    resp = 'x;
    tready = 1'b0;
    araddr = 16'(idx * 8);
    arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge aclk); #1;
      if (arready) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge aclk); #1;
      arvalid = 1'b0;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge aclk);
        if (rvalid) begin ok = 1; break; end
      end
    end
    arvalid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout: got no read response, expected one within 50 cycles");
    end else begin
      data = rdata;
      resp = rresp;
    end
    @(posedge aclk); #1;
    tready = saved;
  endtask

  task automatic rd_chk(input string name, input int idx);
    logic [63:0] d, e;
    logic [1:0]  r, er;
    axil_read(idx, d, r);
    model_read(idx, e, er);
    check(name, 128'(d), 128'(e));
    check({name, "_resp"}, 128'(r), 128'(er));
  endtask

  task automatic wr(input int idx, input logic [63:0] data, input logic [7:0] strb);
    logic [1:0] r;
    logic tv;
    axil_write(idx, data, strb, -1, r, tv);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  typedef struct {
    bit          is_wr;
    int          idx;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_rd;
    logic [1:0]  exp_resp;
  } vec_t;

  initial begin
    vec_t        vt [11];
    logic [63:0] d;
    logic [1:0]  r;
    logic        tv;
    int          b0;

    vt[0]  = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 2'b00};
    vt[1]  = '{1, 0, 64'h0, 8'h01, 64'h0, 2'b00};
    vt[2]  = '{0, 0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF00, 2'b00};
    vt[3]  = '{1, 7, 64'h1234, 8'hFF, 64'h0, 2'b10};
    vt[4]  = '{0, 7, 64'h0, 8'h00, 64'h0, 2'b10};
    vt[5]  = '{0, 0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF00, 2'b00};
    vt[6]  = '{1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 2'b00};
    vt[7]  = '{0, 3, 64'h0, 8'h00, 64'h0000_0000_0002_0000, 2'b00};
    vt[8]  = '{1, 1, 64'hDEAD_BEEF_0000_A5A5, 8'h0F, 64'h0, 2'b00};
    vt[9]  = '{0, 1, 64'h0, 8'h00, 64'h0000_0000_0000_A5A5, 2'b00};
    vt[10] = '{0, 2, 64'h0, 8'h00, 64'h0, 2'b00};

    model_reset();
    #12;
    check("rst_awready", 128'(awready), 128'(0));
    check("rst_bvalid", 128'(bvalid), 128'(0));
    check("rst_arready", 128'(arready), 128'(0));
    check("rst_rvalid", 128'(rvalid), 128'(0));
    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_resp_rdata", {62'(0), bresp, rresp, rdata}, 128'(0));
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Legacy auto-commit on write to the last word
    tready = 1'b1;
    wr(0, 64'h11, 8'hFF);
    b0 = beats;
    axil_write(1, 64'h22, 8'hFF, -1, r, tv);
    check("t1_bresp", 128'(r), 128'(0));
    check("t1_tvalid_next", 128'(tv), 128'(1));
    wait_cycles(3);
    check("t1_beats", 128'(beats - b0), 128'(1));

    // Explicit commit
    wr(2, 64'h0, 8'hFF);
    wr(0, 64'h33, 8'hFF);
    wr(1, 64'h44, 8'hFF);
    wait_cycles(3);
    check("t2_no_tvalid", 128'(tvalid), 128'(0));
    b0 = beats;
    wr(2, 64'h1, 8'hFF);
    wait_cycles(3);
    check("t2_beats", 128'(beats - b0), 128'(1));
    axil_read(2, d, r);
    check("t2_ctrl_rd", 128'(d), 128'(0));

    // Overflow: 6 commits into a depth-4 FIFO with the stream stalled
    tready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr(0, 64'(100 + k), 8'hFF);
      wr(2, 64'h1, 8'h01);
    end
    axil_read(3, d, r);
    check("t3_status", 128'(d), 128'h0000_0004_0005_0002);
    rd_chk("t3_status_model", 3);
    b0 = beats;
    tready = 1'b1;
    wait_cycles(8);
    check("t3_drain_beats", 128'(beats - b0), 128'(4));

    // Full FIFO with a pop in the exact commit cycle
    wr(2, 64'h2, 8'h01);
    axil_read(3, d, r);
    check("t4_cleared", 128'(d), 128'h0000_0000_0002_0000);
    tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr(1, 64'(200 + k), 8'hFF);
      wr(2, 64'h1, 8'h01);
    end
    b0 = beats;
    wr(0, 64'h77, 8'hFF);
    axil_write(2, 64'h1, 8'h01, 1, r, tv);
    check("t4_one_pop", 128'(beats - b0), 128'(1));
    axil_read(3, d, r);
    check("t4_status", 128'(d), 128'h0000_0004_0004_0000);
    tready = 1'b1;
    wait_cycles(8);
    check("t4_drained", 128'(m_q.size()), 128'(0));

    // Vector table: byte strobes, error decode, read-only STATUS
    tready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (vt[i].is_wr) begin
        axil_write(vt[i].idx, vt[i].data, vt[i].strb, -1, r, tv);
        check($sformatf("vec%0d_bresp", i), 128'(r), 128'(vt[i].exp_resp));
      end else begin
        axil_read(vt[i].idx, d, r);
        check($sformatf("vec%0d_rdata", i), 128'(d), 128'(vt[i].exp_rd));
        check($sformatf("vec%0d_rresp", i), 128'(r), 128'(vt[i].exp_resp));
      end
    end

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      int op = $urandom_range(0, 9);
      tready = 1'($urandom_range(0, 1));
      if (op <= 3)
        wr($urandom_range(0, NW - 1), {$urandom, $urandom}, 8'($urandom));
      else if (op <= 5)
        wr(NW, 64'($urandom_range(0, 7)), {7'($urandom), 1'($urandom_range(0, 3) != 0)});
      else if (op == 6)
        wr($urandom_range(NW + 1, 7), {$urandom, $urandom}, 8'($urandom));
      else
        rd_chk("rand_rd", $urandom_range(0, 7));
    end
    tready = 1'b1;
    wait_cycles(10);
    check("rand_drained", 128'(m_q.size()), 128'(0));
    rd_chk("rand_status", 3);

    // Reset with queued entries and a pending write response
    tready = 1'b0;
    wr(2, 64'h2, 8'h01);
    for (int k = 0; k < 3; k++) wr(2, 64'h1, 8'h01);
    bready = 1'b0;
    wr(0, 64'h55, 8'hFF);
    check("t6_pre_bvalid", 128'(bvalid), 128'(1));
    check("t6_pre_tvalid", 128'(tvalid), 128'(1));
    aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 128'(tvalid), 128'(0));
    check("t6_rst_bvalid", 128'(bvalid), 128'(0));
    model_reset();
    wait_cycles(2);
    aresetn = 1'b1;
    bready = 1'b1;
    wait_cycles(1);
    axil_read(3, d, r);
    check("t6_status", 128'(d), 128'h0000_0000_0002_0000);
    rd_chk("t6_ctrl", 2);
    rd_chk("t6_word0", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
